mem_wb_pipe: RTL and testbench

Parametrised MEM/WB pipeline stage with a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush, and x0 write squashing.
- Selects the write-back data (load vs ALU result) at capture, so WB sees a single registered data bus.
- Exports a forwarding tap and a saturating back-pressure counter.
- Sits between the MEM stage (upstream) and the register-file write port (downstream).

---
 rtl/mem_wb_pipe_pkg.sv | 14 +
 rtl/mem_wb_pipe_if.sv | 38 +++
 rtl/mem_wb_pipe_skid_buf.sv | 128 ++++++++++++
 rtl/mem_wb_pipe.sv | 82 ++++++++
 tb/tb_mem_wb_pipe.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: shared definitions for the MEM/WB pipeline slice.
//   hs_state_e : handshake occupancy of the skid buffer (empty / main only / main + skid)
//   RegX0      : index of the hard-wired zero register; writes to it are squashed
package mem_wb_pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } hs_state_e;

    localparam int unsigned RegX0 = 0;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: MEM -> WB handshake bundle.
//   in_*  : upstream entry (valid/ready, write enable, load select, load data, ALU result, rd)
//   out_* : downstream write-back entry (valid/ready, write enable, selected data, rd)
//   master: the MEM side / environment driving entries and out_ready
//   slave : the pipeline stage itself
interface mem_wb_pipe_if #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned REGADDR_WIDTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_reg_write;
    logic                     in_mem_read;
    logic [DATA_WIDTH-1:0]    in_read_data;
    logic [DATA_WIDTH-1:0]    in_alu_result;
    logic [REGADDR_WIDTH-1:0] in_rd;

    logic                     out_valid;
    logic                     out_ready;
    logic                     out_reg_write;
    logic [DATA_WIDTH-1:0]    out_wb_data;
    logic [REGADDR_WIDTH-1:0] out_rd;

    modport master (
        output in_valid, in_reg_write, in_mem_read, in_read_data, in_alu_result, in_rd,
        output out_ready,
        input  in_ready,
        input  out_valid, out_reg_write, out_wb_data, out_rd
    );

    modport slave (
        input  in_valid, in_reg_write, in_mem_read, in_read_data, in_alu_result, in_rd,
        input  out_ready,
        output in_ready,
        output out_valid, out_reg_write, out_wb_data, out_rd
    );

endinterface

// File: rtl/mem_wb_pipe_skid_buf.sv
// mem_wb_pipe_skid_buf: generic payload skid buffer with synchronous flush.
//   clk, reset (async, active-high), flush (drops all held entries next cycle)
//   in_valid/in_ready/in_data   : upstream handshake
//   out_valid/out_ready/out_data: downstream handshake, out_data is the main register
// SKID_EN=1: main + skid register, in_ready decoded from the state register only.
// SKID_EN=0: single register, in_ready = !out_valid | out_ready (combinational).
module mem_wb_pipe_skid_buf
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SKID_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (SKID_EN != 0) begin : g_skid
        hs_state_e        state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             accept, consume;

        assign accept  = in_valid & in_ready;
        assign consume = out_valid & out_ready;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StEmpty;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            if (flush) begin
                state_d = StEmpty;
            end else begin
                unique case (state_q)
                    StEmpty: if (accept) state_d = StFull;
                    StFull: begin
                        if (accept && !consume) begin
                            state_d = StSkid;
                        end else if (!accept && consume) begin
                            state_d = StEmpty;
                        end
                    end
                    StSkid:  if (consume) state_d = StFull;
                    default: state_d = StEmpty;
                endcase
            end
        end

        always_comb begin
            out_valid = (state_q != StEmpty);
            in_ready  = (state_q != StSkid);
        end

        // In StSkid in_ready is low, so the only possible move is skid -> main.
        // Otherwise a new entry lands in main when main is free (or draining this
        // cycle), else it parks in skid behind the older main entry.
        always_comb begin
            main_d = main_q;
            skid_d = skid_q;
            if (state_q == StSkid) begin
                if (consume) main_d = skid_q;
            end else if (accept) begin
                if (state_q == StEmpty || consume) begin
                    main_d = in_data;
                end else begin
                    skid_d = in_data;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                main_q <= main_d;
                skid_q <= skid_d;
            end
        end

        assign out_data = main_q;
    end else begin : g_single
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;

        always_comb begin
            in_ready  = !valid_q || out_ready;
            out_valid = valid_q;
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (in_valid && in_ready) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (out_valid && out_ready) begin
                valid_d = 1'b0;
            end
            if (flush) valid_d = 1'b0;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_data = data_q;
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline stage.
//   clk, reset (async, active-high), flush (sync squash of held entries)
//   bus       : mem_wb_pipe_if slave (MEM-side entry in, WB-side entry out)
//   fwd_valid/fwd_rd/fwd_data : forwarding tap from the output register only
//   stall_cnt : saturating count of cycles with out_valid & !out_ready
// Write-back data is selected at capture so WB sees one registered data bus.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned REGADDR_WIDTH = 4,
    parameter int unsigned SKID_EN       = 1,
    parameter int unsigned ZERO_SQUASH   = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    mem_wb_pipe_if.slave             bus,
    output logic                     fwd_valid,
    output logic [REGADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]    fwd_data,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    typedef struct packed {
        logic                     reg_write;
        logic [DATA_WIDTH-1:0]    wb_data;
        logic [REGADDR_WIDTH-1:0] rd;
    } wb_payload_t;

    wb_payload_t          in_payload, out_payload;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        in_payload.wb_data   = bus.in_mem_read ? bus.in_read_data : bus.in_alu_result;
        in_payload.rd        = bus.in_rd;
        in_payload.reg_write = bus.in_reg_write &&
            !((ZERO_SQUASH != 0) && (bus.in_rd == REGADDR_WIDTH'(RegX0)));
    end

    mem_wb_pipe_skid_buf #(
        .WIDTH   ($bits(wb_payload_t)),
        .SKID_EN (SKID_EN)
    ) u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign bus.out_reg_write = out_payload.reg_write;
    assign bus.out_wb_data   = out_payload.wb_data;
    assign bus.out_rd        = out_payload.rd;

    assign fwd_valid = bus.out_valid & out_payload.reg_write;
    assign fwd_rd    = out_payload.rd;
    assign fwd_data  = out_payload.wb_data;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.out_valid && !bus.out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: self-checking bench for mem_wb_pipe.
// Three instances share one stimulus: default (skid, 16-bit counter), SKID_EN=0,
// and CNT_WIDTH=4. A queue model of each stage is compared every cycle, and
// directed literal expectations pin the model at key points.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_reg_write = 1'b0;
    logic        in_mem_read = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_read_data = '0;
    logic [15:0] in_alu_result = '0;
    logic [3:0]  in_rd = '0;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_WIDTH(16), .REGADDR_WIDTH(4)) bus1 ();
    mem_wb_pipe_if #(.DATA_WIDTH(16), .REGADDR_WIDTH(4)) bus0 ();
    mem_wb_pipe_if #(.DATA_WIDTH(16), .REGADDR_WIDTH(4)) busc ();

    assign {bus1.in_valid, bus1.in_reg_write, bus1.in_mem_read, bus1.in_read_data,
            bus1.in_alu_result, bus1.in_rd, bus1.out_ready} =
           {in_valid, in_reg_write, in_mem_read, in_read_data, in_alu_result, in_rd, out_ready};
    assign {bus0.in_valid, bus0.in_reg_write, bus0.in_mem_read, bus0.in_read_data,
            bus0.in_alu_result, bus0.in_rd, bus0.out_ready} =
           {in_valid, in_reg_write, in_mem_read, in_read_data, in_alu_result, in_rd, out_ready};
    assign {busc.in_valid, busc.in_reg_write, busc.in_mem_read, busc.in_read_data,
            busc.in_alu_result, busc.in_rd, busc.out_ready} =
           {in_valid, in_reg_write, in_mem_read, in_read_data, in_alu_result, in_rd, out_ready};

    logic        fv1, fv0, fvc;
    logic [3:0]  frd1, frd0, frdc;
    logic [15:0] fd1, fd0, fdc;
    logic [15:0] cnt1, cnt0;
    logic [3:0]  cntc;

    mem_wb_pipe #(.SKID_EN(1), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus1),
        .fwd_valid(fv1), .fwd_rd(frd1), .fwd_data(fd1), .stall_cnt(cnt1)
    );
    mem_wb_pipe #(.SKID_EN(0), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus0),
        .fwd_valid(fv0), .fwd_rd(frd0), .fwd_data(fd0), .stall_cnt(cnt0)
    );
    mem_wb_pipe #(.SKID_EN(1), .CNT_WIDTH(4)) u_dutc (
        .clk(clk), .reset(reset), .flush(flush), .bus(busc),
        .fwd_valid(fvc), .fwd_rd(frdc), .fwd_data(fdc), .stall_cnt(cntc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a stage is a FIFO of held entries. Skid stage holds up to 2 and is
    // ready while not full; single stage holds 1 and is ready when empty or draining.
    typedef struct {
        logic        rw;
        logic [15:0] d;
        logic [3:0]  rd;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];
    int   n1 = 0;
    int   n0 = 0;

    always @(posedge clk or posedge reset) begin : model
        ent_t e;
        bit   acc, con;
        if (reset) begin
            q1.delete();
            q0.delete();
            n1 = 0;
            n0 = 0;
        end else begin
            e.rw = in_reg_write && (in_rd != 4'd0);
            e.d  = in_mem_read ? in_read_data : in_alu_result;
            e.rd = in_rd;

            if (q1.size() != 0 && !out_ready) n1 = n1 + 1;
            acc = in_valid && (q1.size() < 2);
            con = (q1.size() != 0) && out_ready;
            if (flush) begin
                q1.delete();
            end else begin
                if (con) void'(q1.pop_front());
                if (acc) q1.push_back(e);
            end

            if (q0.size() != 0 && !out_ready) n0 = n0 + 1;
            acc = in_valid && (q0.size() == 0 || out_ready);
            con = (q0.size() != 0) && out_ready;
            if (flush) begin
                q0.delete();
            end else begin
                if (con) void'(q0.pop_front());
                if (acc) q0.push_back(e);
            end
        end
    end

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("d1 out_valid", 32'(bus1.out_valid), 32'(q1.size() != 0));
            chk("d1 in_ready", 32'(bus1.in_ready), 32'(q1.size() < 2));
            chk("d1 stall_cnt", 32'(cnt1), 32'(sat(n1, 65535)));
            chk("dc out_valid", 32'(busc.out_valid), 32'(q1.size() != 0));
            chk("dc stall_cnt", 32'(cntc), 32'(sat(n1, 15)));
            if (q1.size() != 0) begin
                chk("d1 wb_data", 32'(bus1.out_wb_data), 32'(q1[0].d));
                chk("d1 rd", 32'(bus1.out_rd), 32'(q1[0].rd));
                chk("d1 reg_write", 32'(bus1.out_reg_write), 32'(q1[0].rw));
                chk("d1 fwd_valid", 32'(fv1), 32'(q1[0].rw));
                chk("d1 fwd_data", 32'(fd1), 32'(q1[0].d));
                chk("d1 fwd_rd", 32'(frd1), 32'(q1[0].rd));
                chk("dc wb_data", 32'(busc.out_wb_data), 32'(q1[0].d));
            end else begin
                chk("d1 fwd_valid idle", 32'(fv1), 32'd0);
            end
            chk("d0 out_valid", 32'(bus0.out_valid), 32'(q0.size() != 0));
            chk("d0 in_ready", 32'(bus0.in_ready), 32'(q0.size() == 0 || out_ready));
            chk("d0 stall_cnt", 32'(cnt0), 32'(sat(n0, 65535)));
            if (q0.size() != 0) begin
                chk("d0 wb_data", 32'(bus0.out_wb_data), 32'(q0[0].d));
                chk("d0 rd", 32'(bus0.out_rd), 32'(q0[0].rd));
                chk("d0 fwd_valid", 32'(fv0), 32'(q0[0].rw));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic [15:0] rdata,
                         input logic [15:0] alu, input logic [3:0] rd);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_read_data  = rdata;
        in_alu_result = alu;
        in_rd         = rd;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus1.in_ready), 32'd1);
        chk("rst wb_data", 32'(bus1.out_wb_data), 32'd0);
        chk("rst stall_cnt", 32'(cnt1), 32'd0);

        // Streaming, zero bubbles
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0, 16'(i), 4'(i));
            tick();
            chk("stream data", 32'(bus1.out_wb_data), 32'(i));
            chk("stream valid", 32'(bus1.out_valid), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        chk("stream drained", 32'(bus1.out_valid), 32'd0);
        chk("stream stall_cnt", 32'(cnt1), 32'd0);

        // Load select, then x0 squash
        drive(1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 4'd3);
        tick();
        chk("load data", 32'(bus1.out_wb_data), 32'hBEEF);
        chk("load reg_write", 32'(bus1.out_reg_write), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h5555, 4'd0);
        tick();
        chk("x0 reg_write", 32'(bus1.out_reg_write), 32'd0);
        chk("x0 fwd_valid", 32'(fv1), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        tick();

        // Back-pressure into the skid register
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00AA, 4'd1);
        tick();
        chk("bp in_ready after A", 32'(bus1.in_ready), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00BB, 4'd2);
        tick();
        chk("bp in_ready after B", 32'(bus1.in_ready), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        repeat (4) tick();
        chk("bp hold A", 32'(bus1.out_wb_data), 32'h00AA);
        chk("bp stall_cnt", 32'(cnt1), 32'd5);
        chk("single in_ready full", 32'(bus0.in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("single in_ready comb", 32'(bus0.in_ready), 32'd1);
        chk("skid in_ready reg", 32'(bus1.in_ready), 32'd0);
        tick();
        chk("bp then B", 32'(bus1.out_wb_data), 32'h00BB);
        tick();
        chk("bp drained", 32'(bus1.out_valid), 32'd0);

        // Flush while in SKID, and flush discarding a same-cycle accept
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00DD, 4'd4);
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00EE, 4'd5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00CC, 4'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("flush out_valid", 32'(bus1.out_valid), 32'd0);
        chk("flush in_ready", 32'(bus1.in_ready), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h00F0, 4'd7);
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h0077, 4'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush nothing left", 32'(bus1.out_valid), 32'd0);
        end

        // Async reset in the middle of a stall
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h0042, 4'd2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("areset out_valid", 32'(bus1.out_valid), 32'd0);
        chk("areset stall_cnt", 32'(cnt1), 32'd0);
        chk("areset wb_data", 32'(bus1.out_wb_data), 32'd0);
        chk("areset rd", 32'(bus1.out_rd), 32'd0);
        chk("areset reg_write", 32'(bus1.out_reg_write), 32'd0);
        chk("areset d0 valid", 32'(bus0.out_valid), 32'd0);
        chk("areset d0 stall", 32'(cnt0), 32'd0);
        tick();
        reset = 1'b0;

        // Counter saturation
        drive(1'b1, 1'b1, 1'b0, 16'h0, 16'h0033, 4'd3);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        repeat (20) tick();
        chk("sat cnt16", 32'(cnt1), 32'd20);
        chk("sat cnt4", 32'(cntc), 32'd15);
        out_ready = 1'b1;
        tick();
        chk("cnt holds", 32'(cnt1), 32'd20);
        chk("cnt4 holds", 32'(cntc), 32'd15);
        tick();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
